// File: rtl/hpdmc_ddr_wrseq.sv
// -----------------------------------------------------------------------------
// hpdmc_ddr_wrseq
//
// DDR write-burst sequencer for the HPDMC datapath. It fetches write data and
// byte masks over a simple fetch handshake. It schedules the DQS preamble,
// toggling and postamble. It drives registered rise/fall pairs straight into
// the per-bit DDR output cells and their tristate enables.
//
// Parameters
//   DQ_WIDTH   : DQ bus width, a multiple of 8 (L = DQ_WIDTH/8 byte lanes)
//   BURST_LEN  : DDR beats per burst, even and >= 2 (N = BURST_LEN/2 cycles)
//   CONTINUOUS : 1 lets a start accepted in the last data cycle chain the
//                next burst with no preamble/postamble gap
//
// Ports
//   sys_clk        : single clock, all state changes on the rising edge
//   sdram_rst      : synchronous active-high reset
//   start          : burst request, only honoured while ready=1
//   ready          : sequencer can accept start this cycle
//   fetch          : data_in/mask_in must be valid, sampled at the closing edge
//   data_in        : beat pair, low half = rising beat, high half = falling
//   mask_in        : byte masks, same split, 1 = byte masked
//   dq_d0/dq_d1    : rising/falling DQ data
//   dm_d0/dm_d1    : rising/falling DM
//   dqs_d0/dqs_d1  : rising/falling DQS level
//   dq_oe          : DQ/DM output enable
//   dqs_oe         : DQS output enable
//
// Every output is a register. The next-cycle value is decoded from the next
// state. Nothing on an output is combinational from an input.
// -----------------------------------------------------------------------------
module hpdmc_ddr_wrseq #(
    parameter int unsigned DQ_WIDTH   = 16,
    parameter int unsigned BURST_LEN  = 4,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic                        sys_clk,
    input  logic                        sdram_rst,
    input  logic                        start,
    output logic                        ready,
    output logic                        fetch,
    input  logic [2*DQ_WIDTH-1:0]       data_in,
    input  logic [2*(DQ_WIDTH/8)-1:0]   mask_in,
    output logic [DQ_WIDTH-1:0]         dq_d0,
    output logic [DQ_WIDTH-1:0]         dq_d1,
    output logic [DQ_WIDTH/8-1:0]       dm_d0,
    output logic [DQ_WIDTH/8-1:0]       dm_d1,
    output logic [DQ_WIDTH/8-1:0]       dqs_d0,
    output logic [DQ_WIDTH/8-1:0]       dqs_d1,
    output logic                        dq_oe,
    output logic                        dqs_oe
);

    localparam int unsigned L  = DQ_WIDTH / 8;
    localparam int unsigned N  = BURST_LEN / 2;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_POST = 2'd3
    } state_t;

    // State and data-cycle counter
    state_t           r_state;
    logic [KW-1:0]    r_k;

    // Registered outputs
    logic             r_ready;
    logic             r_fetch;
    logic [DQ_WIDTH-1:0] r_dq_d0;
    logic [DQ_WIDTH-1:0] r_dq_d1;
    logic [L-1:0]     r_dm_d0;
    logic [L-1:0]     r_dm_d1;
    logic [L-1:0]     r_dqs_d0;
    logic [L-1:0]     r_dqs_d1;
    logic             r_dq_oe;
    logic             r_dqs_oe;

    // Next-state / next-output decode
    state_t           w_state_nxt;
    logic [KW-1:0]    w_k_nxt;
    logic             w_load;
    logic             w_ready_nxt;
    logic             w_fetch_nxt;
    logic [L-1:0]     w_dqs_d0_nxt;
    logic             w_dq_oe_nxt;
    logic             w_dqs_oe_nxt;

    // -------------------------------------------------------------------------
    // Next state. w_load marks every edge that enters a data cycle. That is
    // exactly the edge at which the fetched beat pair is captured.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned. An unassigned path would infer a latch.
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PRE;
                end
            end

            S_PRE: begin
                w_state_nxt = S_DATA;
                w_k_nxt     = '0;
                w_load      = 1'b1;
            end

            S_DATA: begin
                if (r_k != K_LAST) begin
                    w_k_nxt = r_k + KW'(1);
                    w_load  = 1'b1;
                end else if (CONTINUOUS && start) begin
                    // Chain: the pair fetched in this last cycle is beat
                    // pair 0 of the next burst.
                    w_state_nxt = S_DATA;
                    w_k_nxt     = '0;
                    w_load      = 1'b1;
                end else begin
                    // Any pair fetched speculatively here is dropped.
                    w_state_nxt = S_POST;
                end
            end

            S_POST: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode for the cycle that follows the coming edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_ready_nxt  = 1'b0;
        w_fetch_nxt  = 1'b0;
        w_dqs_d0_nxt = '0;
        w_dq_oe_nxt  = 1'b0;
        w_dqs_oe_nxt = 1'b0;

        case (w_state_nxt)
            S_IDLE: begin
                w_ready_nxt = 1'b1;
            end

            S_PRE: begin
                w_dqs_oe_nxt = 1'b1;
                w_fetch_nxt  = 1'b1;
            end

            S_DATA: begin
                w_dq_oe_nxt  = 1'b1;
                w_dqs_oe_nxt = 1'b1;
                w_dqs_d0_nxt = '1;
                if (w_k_nxt != K_LAST) begin
                    w_fetch_nxt = 1'b1;
                end else if (CONTINUOUS) begin
                    // Last data cycle opens the chaining window. Fetch
                    // speculatively for pair 0 of a possible next burst.
                    w_ready_nxt = 1'b1;
                    w_fetch_nxt = 1'b1;
                end
            end

            S_POST: begin
                w_dqs_oe_nxt = 1'b1;
            end

            default: begin
                w_ready_nxt = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers. Reset is synchronous and wins from any
    // state. An interrupted burst gets no postamble.
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples pre-edge values, whatever the statement order.
        if (sdram_rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_ready  <= 1'b1;
            r_fetch  <= 1'b0;
            r_dq_d0  <= '0;
            r_dq_d1  <= '0;
            r_dm_d0  <= '0;
            r_dm_d1  <= '0;
            r_dqs_d0 <= '0;
            r_dqs_d1 <= '0;
            r_dq_oe  <= 1'b0;
            r_dqs_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_k      <= w_k_nxt;
            r_ready  <= w_ready_nxt;
            r_fetch  <= w_fetch_nxt;
            r_dqs_d0 <= w_dqs_d0_nxt;
            r_dqs_d1 <= '0;
            r_dq_oe  <= w_dq_oe_nxt;
            r_dqs_oe <= w_dqs_oe_nxt;
            // Each data cycle is entered through a load. Outside data cycles
            // DQ/DM therefore return to zero.
            if (w_load) begin
                r_dq_d0 <= data_in[DQ_WIDTH-1:0];
                r_dq_d1 <= data_in[2*DQ_WIDTH-1:DQ_WIDTH];
                r_dm_d0 <= mask_in[L-1:0];
                r_dm_d1 <= mask_in[2*L-1:L];
            end else begin
                r_dq_d0 <= '0;
                r_dq_d1 <= '0;
                r_dm_d0 <= '0;
                r_dm_d1 <= '0;
            end
        end
    end

    assign ready  = r_ready;
    assign fetch  = r_fetch;
    assign dq_d0  = r_dq_d0;
    assign dq_d1  = r_dq_d1;
    assign dm_d0  = r_dm_d0;
    assign dm_d1  = r_dm_d1;
    assign dqs_d0 = r_dqs_d0;
    assign dqs_d1 = r_dqs_d1;
    assign dq_oe  = r_dq_oe;
    assign dqs_oe = r_dqs_oe;

endmodule

// File: tb/tb_hpdmc_ddr_wrseq.sv
// -----------------------------------------------------------------------------
// tb_hpdmc_ddr_wrseq
//
// Directed bench for hpdmc_ddr_wrseq. It uses three instances:
//   u_dut_a : DQ_WIDTH=16, BURST_LEN=4, CONTINUOUS=0
//   u_dut_c : DQ_WIDTH=16, BURST_LEN=4, CONTINUOUS=1
//   u_dut_w : DQ_WIDTH=32, BURST_LEN=8, CONTINUOUS=0
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the
// same point, which is a full half-period away from the next active edge.
// Status nibbles are {ready, fetch, dq_oe, dqs_oe}.
// -----------------------------------------------------------------------------
module tb_hpdmc_ddr_wrseq;

    logic sys_clk = 1'b0;
    logic sdram_rst;

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected status nibbles {ready, fetch, dq_oe, dqs_oe}
    localparam logic [3:0] ST_IDLE = 4'b1000;
    localparam logic [3:0] ST_PRE  = 4'b0101;
    localparam logic [3:0] ST_DMID = 4'b0111;
    localparam logic [3:0] ST_DLST = 4'b0011;
    localparam logic [3:0] ST_DCHN = 4'b1111;
    localparam logic [3:0] ST_POST = 4'b0001;

    // ---------------- instance A: 16/4, non-continuous ----------------------
    logic        a_start;
    logic [31:0] a_data;
    logic [3:0]  a_mask;
    logic        a_ready, a_fetch, a_dq_oe, a_dqs_oe;
    logic [15:0] a_dq_d0, a_dq_d1;
    logic [1:0]  a_dm_d0, a_dm_d1, a_dqs_d0, a_dqs_d1;

    hpdmc_ddr_wrseq #(.DQ_WIDTH(16), .BURST_LEN(4), .CONTINUOUS(1'b0)) u_dut_a (
        .sys_clk(sys_clk), .sdram_rst(sdram_rst), .start(a_start),
        .ready(a_ready), .fetch(a_fetch), .data_in(a_data), .mask_in(a_mask),
        .dq_d0(a_dq_d0), .dq_d1(a_dq_d1), .dm_d0(a_dm_d0), .dm_d1(a_dm_d1),
        .dqs_d0(a_dqs_d0), .dqs_d1(a_dqs_d1), .dq_oe(a_dq_oe), .dqs_oe(a_dqs_oe)
    );

    // ---------------- instance C: 16/4, continuous --------------------------
    logic        c_start;
    logic [31:0] c_data;
    logic [3:0]  c_mask;
    logic        c_ready, c_fetch, c_dq_oe, c_dqs_oe;
    logic [15:0] c_dq_d0, c_dq_d1;
    logic [1:0]  c_dm_d0, c_dm_d1, c_dqs_d0, c_dqs_d1;

    hpdmc_ddr_wrseq #(.DQ_WIDTH(16), .BURST_LEN(4), .CONTINUOUS(1'b1)) u_dut_c (
        .sys_clk(sys_clk), .sdram_rst(sdram_rst), .start(c_start),
        .ready(c_ready), .fetch(c_fetch), .data_in(c_data), .mask_in(c_mask),
        .dq_d0(c_dq_d0), .dq_d1(c_dq_d1), .dm_d0(c_dm_d0), .dm_d1(c_dm_d1),
        .dqs_d0(c_dqs_d0), .dqs_d1(c_dqs_d1), .dq_oe(c_dq_oe), .dqs_oe(c_dqs_oe)
    );

    // ---------------- instance W: 32/8, non-continuous ----------------------
    logic        w_start;
    logic [63:0] w_data;
    logic [7:0]  w_mask;
    logic        w_ready, w_fetch, w_dq_oe, w_dqs_oe;
    logic [31:0] w_dq_d0, w_dq_d1;
    logic [3:0]  w_dm_d0, w_dm_d1, w_dqs_d0, w_dqs_d1;

    hpdmc_ddr_wrseq #(.DQ_WIDTH(32), .BURST_LEN(8), .CONTINUOUS(1'b0)) u_dut_w (
        .sys_clk(sys_clk), .sdram_rst(sdram_rst), .start(w_start),
        .ready(w_ready), .fetch(w_fetch), .data_in(w_data), .mask_in(w_mask),
        .dq_d0(w_dq_d0), .dq_d1(w_dq_d1), .dm_d0(w_dm_d0), .dm_d1(w_dm_d1),
        .dqs_d0(w_dqs_d0), .dqs_d1(w_dqs_d1), .dq_oe(w_dq_oe), .dqs_oe(w_dqs_oe)
    );

    wire [3:0] a_st = {a_ready, a_fetch, a_dq_oe, a_dqs_oe};
    wire [3:0] c_st = {c_ready, c_fetch, c_dq_oe, c_dqs_oe};
    wire [3:0] w_st = {w_ready, w_fetch, w_dq_oe, w_dqs_oe};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Snapshot of everything instance A drives
    task automatic check_a(input string tag, input logic [3:0] st,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [1:0] m0, input logic [1:0] m1,
                           input logic [1:0] q0);
        check({tag, ".st"},   64'(a_st),     64'(st));
        check({tag, ".dq0"},  64'(a_dq_d0),  64'(d0));
        check({tag, ".dq1"},  64'(a_dq_d1),  64'(d1));
        check({tag, ".dm0"},  64'(a_dm_d0),  64'(m0));
        check({tag, ".dm1"},  64'(a_dm_d1),  64'(m1));
        check({tag, ".dqs0"}, 64'(a_dqs_d0), 64'(q0));
        check({tag, ".dqs1"}, 64'(a_dqs_d1), 64'(0));
    endtask

    initial begin
        logic [3:0]  exp_seq [10];
        logic [63:0] w_pairs [4];

        sdram_rst = 1'b1;
        a_start = 1'b0; a_data = '0; a_mask = '0;
        c_start = 1'b0; c_data = '0; c_mask = '0;
        w_start = 1'b0; w_data = '0; w_mask = '0;
        tick();
        tick();
        sdram_rst = 1'b0;

        // ---------------- reset state --------------------------------------
        check_a("rst_a", ST_IDLE, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00);
        check("rst_c", 64'(c_st), 64'(ST_IDLE));
        check("rst_w", 64'(w_st), 64'(ST_IDLE));

        // ---------------- single burst with mask on pair 0 -----------------
        a_start = 1'b1;
        tick();                                   // E0 -> PRE
        check_a("b1_pre", ST_PRE, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00);
        a_start = 1'b0;
        a_data  = 32'h2222_1111;
        a_mask  = 4'b0110;
        tick();                                   // E1 -> D0
        check_a("b1_d0", ST_DMID, 16'h1111, 16'h2222, 2'b10, 2'b01, 2'b11);
        a_data  = 32'h4444_3333;
        a_mask  = 4'b0000;
        tick();                                   // E2 -> D1
        check_a("b1_d1", ST_DLST, 16'h3333, 16'h4444, 2'b00, 2'b00, 2'b11);
        a_data  = 32'hDEAD_BEEF;
        a_mask  = 4'b1111;
        a_start = 1'b1;                           // busy: must be ignored
        tick();                                   // E3 -> POST
        check_a("b1_post", ST_POST, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00);
        a_start = 1'b0;
        tick();                                   // E4 -> IDLE
        check_a("b1_idle", ST_IDLE, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00);
        tick();
        check("b1_idle_hold", 64'(a_st), 64'(ST_IDLE));

        // ---------------- non-continuous, start held high ------------------
        exp_seq = '{ST_PRE, ST_DMID, ST_DLST, ST_POST, ST_IDLE,
                    ST_PRE, ST_DMID, ST_DLST, ST_POST, ST_IDLE};
        a_start = 1'b1;
        a_data  = 32'h5555_AAAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("held_a_%0d", i), 64'(a_st), 64'(exp_seq[i]));
        end
        a_start = 1'b0;
        tick();
        check("held_a_stop", 64'(a_st), 64'(ST_IDLE));

        // ---------------- continuous, 2 chained bursts ---------------------
        c_start = 1'b1;
        tick();                                   // PRE
        check("chn_pre", 64'(c_st), 64'(ST_PRE));
        c_data = 32'hB000_A000;
        tick();                                   // burst0 D0
        check("chn_b0d0_st", 64'(c_st), 64'(ST_DMID));
        check("chn_b0d0_dq", 64'({c_dq_d1, c_dq_d0}), 64'h0000_0000_B000_A000);
        c_data = 32'hB001_A001;
        tick();                                   // burst0 D1, ready=1
        check("chn_b0d1_st", 64'(c_st), 64'(ST_DCHN));
        check("chn_b0d1_dq", 64'({c_dq_d1, c_dq_d0}), 64'h0000_0000_B001_A001);
        c_data = 32'hB010_A010;
        tick();                                   // burst1 D0 via chain
        check("chn_b1d0_st", 64'(c_st), 64'(ST_DMID));
        check("chn_b1d0_dq", 64'({c_dq_d1, c_dq_d0}), 64'h0000_0000_B010_A010);
        check("chn_b1d0_dqs", 64'(c_dqs_d0), 64'(2'b11));
        c_data  = 32'hB011_A011;
        c_start = 1'b0;
        tick();                                   // burst1 D1
        check("chn_b1d1_st", 64'(c_st), 64'(ST_DCHN));
        check("chn_b1d1_dq", 64'({c_dq_d1, c_dq_d0}), 64'h0000_0000_B011_A011);
        c_data = 32'hFFFF_FFFF;                   // speculative, discarded
        tick();
        check("chn_post_st", 64'(c_st), 64'(ST_POST));
        check("chn_post_dq", 64'({c_dq_d1, c_dq_d0}), 64'h0);
        tick();
        check("chn_idle_st", 64'(c_st), 64'(ST_IDLE));

        // ---------------- wide instance: 32-bit DQ, BL8 --------------------
        w_pairs = '{64'h0202_0202_0101_0101, 64'h0404_0404_0303_0303,
                    64'h0606_0606_0505_0505, 64'h0808_0808_0707_0707};
        w_start = 1'b1;
        tick();
        check("w_pre", 64'(w_st), 64'(ST_PRE));
        w_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            w_data = w_pairs[j];
            w_mask = 8'(j + 1);
            tick();
            check($sformatf("w_d%0d_st", j), 64'(w_st), (j < 3) ? 64'(ST_DMID) : 64'(ST_DLST));
            check($sformatf("w_d%0d_dq0", j), 64'(w_dq_d0), 64'(w_pairs[j][31:0]));
            check($sformatf("w_d%0d_dq1", j), 64'(w_dq_d1), 64'(w_pairs[j][63:32]));
            check($sformatf("w_d%0d_dm0", j), 64'(w_dm_d0), 64'((j + 1) & 4'hF));
            check($sformatf("w_d%0d_dqs0", j), 64'(w_dqs_d0), 64'(4'hF));
        end
        tick();
        check("w_post", 64'(w_st), 64'(ST_POST));
        check("w_post_dqs0", 64'(w_dqs_d0), 64'(0));
        tick();
        check("w_idle", 64'(w_st), 64'(ST_IDLE));

        // ---------------- reset in data cycle 1 ----------------------------
        a_start = 1'b1;
        tick();                                   // PRE
        a_start = 1'b0;
        a_data  = 32'h7777_6666;
        a_mask  = 4'b1001;
        tick();                                   // D0
        a_data  = 32'h9999_8888;
        tick();                                   // D1
        check("rmid_d1", 64'(a_st), 64'(ST_DLST));
        sdram_rst = 1'b1;
        tick();
        check_a("rmid_after", ST_IDLE, 16'h0, 16'h0, 2'b00, 2'b00, 2'b00);
        sdram_rst = 1'b0;
        a_start = 1'b1;
        tick();
        check("rmid_pre", 64'(a_st), 64'(ST_PRE));
        a_start = 1'b0;
        a_data  = 32'hCAFE_F00D;
        a_mask  = 4'b0000;
        tick();
        check_a("rmid_d0", ST_DMID, 16'hF00D, 16'hCAFE, 2'b00, 2'b00, 2'b11);
        tick();
        check("rmid_d1b", 64'(a_st), 64'(ST_DLST));
        tick();
        check("rmid_post", 64'(a_st), 64'(ST_POST));
        tick();
        check("rmid_idle", 64'(a_st), 64'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
